servo_pwm_array: RTL and testbench
==================================

# servo_pwm_array

Parametrised multi-channel servo PWM generator. It drives NUM_CH independent hobby-servo outputs from one shared frame counter. Each channel's pulse width is stepped by its own pair of debounced push-buttons, and changes are applied glitch-free at frame boundaries with an optional slew limit. It sits between the board button inputs and the servo header pins, replacing the single-channel fixed-step generator.

## Interface
- PERIOD, 1_000_000: frame length in clk cycles (20 ms at 50 MHz).
- MIN_PULSE, 25_000: lower clamp of pulse width, cycles.
- MAX_PULSE, 125_000: upper clamp of pulse width, cycles.
- CENTER_PULSE, 75_000: reset pulse width, cycles.
- STEP, 10_000: target change per accepted button press, cycles.
- SLEW, 0: maximum change of the active width per frame, cycles; 0 = unlimited (active jumps to target).
- DEB_CYCLES, 500_000: cycles a synchronised button level must be stable before it is accepted.
- NUM_CH, 4: number of channels, 1..16.
- CW, 20: counter/width bit width, must satisfy 2^CW > PERIOD and 2^CW > MAX_PULSE + STEP.
- clk  in  1  single system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- btn_dec  in  NUM_CH  per-channel "decrease width" button, asynchronous, active-high.
- btn_inc  in  NUM_CH  per-channel "increase width" button, asynchronous, active-high.
- pwm_out  out  NUM_CH  registered servo pulse outputs.
- frame_start  out  1  one-cycle strobe, high while the frame counter equals 0.
- width_flat  out  NUM_CH*CW  active width of each channel; channel i occupies bits [i*CW +: CW].

## Operation
- Frame counter: counts 0..PERIOD-1, then wraps to 0. It is shared by all channels.
- Button path per input: a 2-FF synchroniser feeds the debouncer. The debouncer keeps a stable-count counter. It accepts the new level after DEB_CYCLES consecutive equal samples and resets the count on any change. A debounced rising edge produces a one-cycle step event.
- Target update per channel on a step event:
  - dec only: target = max(MIN_PULSE, target − STEP).
  - inc only: target = min(MAX_PULSE, target + STEP).
  - The result is always clamped, never skipped. Example: target 30_000, dec → 25_000, not "no change".
  - dec and inc events in the same cycle: target unchanged.
  - Arithmetic is CW bits wide. Compare before subtracting so no underflow wrap occurs.
- Active width per channel loads only on the cycle where the counter wraps PERIOD-1 → 0:
  - SLEW=0: active ← target.
  - Otherwise active moves toward target by min(|target − active|, SLEW).
- Output: pwm_out[i] ← (counter < active[i]), registered. Width changes never truncate or extend a frame mid-pulse.
- Reset (any cycle, including mid-frame or mid-debounce):
  - counter = 0.
  - target = active = CENTER_PULSE for every channel.
  - Debounced levels and stable counts = 0; synchronisers cleared.
  - pwm_out = 0, frame_start = 0.
  - First cycle after rst deasserts counts as counter 0.

## Timing
- pwm_out lags the counter compare by 1 cycle. The high time is exactly active cycles per frame, and the frame is exactly PERIOD cycles.
- frame_start is registered, aligned with pwm_out rising edges (counter==0 compare registered).
- Button press to step event: 2 sync cycles + DEB_CYCLES + 1 edge cycle.
- Step event to target: 1 cycle. Target to pwm_out: applied at the next frame boundary, then 1 cycle of output register latency.
- Presses arriving faster than one per frame accumulate in target. Only the final target at the boundary is applied.
- width_flat updates on the same edge as active.

## Structure
- Package servo_pkg: default constants (PERIOD, MIN/MAX/CENTER_PULSE, STEP, DEB_CYCLES) and a clamp-step helper function (add/sub with saturation).
- Sub-module servo_btn_debounce (synchroniser + debouncer + rising-edge event), instantiated 2×NUM_CH times via generate.
- Top level holds the frame counter, the per-channel target/active/slew registers and the output compare.

## Test plan
(Run with PERIOD=1000, MIN=100, MAX=500, CENTER=300, STEP=40, DEB_CYCLES=8, NUM_CH=2.)
- Reset, then idle 3 frames → both channels high exactly 300 cycles per 1000-cycle frame; frame_start once per frame.
- Ch0 inc pressed 6×, each press held 20 cycles → target 340, 380, 420, 460, 500, 500 (saturated). Ch1 stays 300.
- Ch0 at target 120, one dec press → 100 (clamped); next dec press → stays 100, no wrap.
- 3-cycle glitch pulses on btn_inc → no step event. inc and dec debounced edges in the same cycle → target unchanged.
- Press mid-pulse at counter 150 → current frame keeps the old width; new width from the next frame_start.
- SLEW=20, target jumps 300→420 → active 320, 340, … 420 over 6 frames. Assert rst mid-frame → all outputs 0 next cycle, widths back to 300.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared defaults and the saturating step helper for the servo PWM array.
// Every constant here can be overridden through the top-level parameters.
package servo_pkg;

  localparam int DEF_PERIOD       = 1_000_000;
  localparam int DEF_MIN_PULSE    = 25_000;
  localparam int DEF_MAX_PULSE    = 125_000;
  localparam int DEF_CENTER_PULSE = 75_000;
  localparam int DEF_STEP         = 10_000;
  localparam int DEF_SLEW         = 0;
  localparam int DEF_DEB_CYCLES   = 500_000;
  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_CW           = 20;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_DEC  = 2'd1,
    STEP_INC  = 2'd2
  } step_dir_e;

  // Saturating add/sub. The comparison runs before the subtraction so a
  // decrement close to the lower bound clamps instead of wrapping.
  function automatic logic [31:0] clamp_step(
    input logic [31:0] val,
    input step_dir_e   dir,
    input logic [31:0] step,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    logic [31:0] res;
    res = val;
    case (dir)
      STEP_INC: res = ((val + step) > hi) ? hi : (val + step);
      STEP_DEC: res = (val < (lo + step)) ? lo : (val - step);
      default:  res = val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/servo_btn_debounce.sv
// One button input: 2-FF synchroniser, stable-count debouncer and a
// registered one-cycle event on each accepted rising edge.
module servo_btn_debounce
  import servo_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic step_o
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] LAST_COUNT = DW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q,  level_d;
  logic          levelDly_q;
  logic [DW-1:0] stable_q, stable_d;
  logic          step_q,   step_d;

  // The count only runs while the synchronised input disagrees with the
  // accepted level; agreeing again at any point restarts it from zero.
  always_comb begin
    level_d  = level_q;
    stable_d = '0;
    step_d   = level_q & ~levelDly_q;
    if (sync2_q != level_q) begin
      if (stable_q == LAST_COUNT) begin
        level_d = sync2_q;
      end else begin
        stable_d = stable_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      levelDly_q <= 1'b0;
      stable_q   <= '0;
      step_q     <= 1'b0;
    end else begin
      sync1_q    <= btn_i;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      levelDly_q <= level_q;
      stable_q   <= stable_d;
      step_q     <= step_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM: shared frame counter, per-channel button-driven
// targets, frame-boundary width loading with optional slew limit.
module servo_pwm_array
  import servo_pkg::*;
#(
  parameter int PERIOD       = DEF_PERIOD,
  parameter int MIN_PULSE    = DEF_MIN_PULSE,
  parameter int MAX_PULSE    = DEF_MAX_PULSE,
  parameter int CENTER_PULSE = DEF_CENTER_PULSE,
  parameter int STEP         = DEF_STEP,
  parameter int SLEW         = DEF_SLEW,
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CW           = DEF_CW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CH-1:0]    btn_dec_i,
  input  logic [NUM_CH-1:0]    btn_inc_i,
  output logic [NUM_CH-1:0]    pwm_out_o,
  output logic                 frame_start_o,
  output logic [NUM_CH*CW-1:0] width_flat_o
);

  localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CENTER_W    = CW'(CENTER_PULSE);
  localparam logic [CW-1:0] SLEW_W      = CW'(SLEW);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wrap;
  logic [NUM_CH-1:0] decEvt;
  logic [NUM_CH-1:0] incEvt;
  logic [CW-1:0]     target_q [NUM_CH];
  logic [CW-1:0]     target_d [NUM_CH];
  logic [CW-1:0]     active_q [NUM_CH];
  logic [CW-1:0]     active_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_q,   pwm_d;
  logic              frame_q, frame_d;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_btn
    servo_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .btn_i  (btn_dec_i[ch]),
      .step_o (decEvt[ch])
    );
    servo_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .btn_i  (btn_inc_i[ch]),
      .step_o (incEvt[ch])
    );
    assign width_flat_o[ch*CW +: CW] = active_q[ch];
  end

  always_comb begin
    wrap  = (cnt_q == PERIOD_LAST);
    cnt_d = wrap ? '0 : (cnt_q + CW'(1));
  end

  // Targets follow button events immediately; the active width only moves
  // on the wrap cycle so a pulse already in progress is never reshaped.
  always_comb begin
    step_dir_e     dir;
    logic [CW-1:0] diff;
    frame_d = (cnt_q == '0);
    for (int i = 0; i < NUM_CH; i++) begin
      dir  = STEP_NONE;
      diff = '0;
      case ({incEvt[i], decEvt[i]})
        2'b10:   dir = STEP_INC;
        2'b01:   dir = STEP_DEC;
        default: dir = STEP_NONE;
      endcase
      target_d[i] = CW'(clamp_step(32'(target_q[i]), dir, 32'(STEP),
                                   32'(MIN_PULSE), 32'(MAX_PULSE)));
      active_d[i] = active_q[i];
      if (wrap) begin
        if (SLEW == 0) begin
          active_d[i] = target_q[i];
        end else if (target_q[i] > active_q[i]) begin
          diff        = target_q[i] - active_q[i];
          active_d[i] = active_q[i] + ((diff > SLEW_W) ? SLEW_W : diff);
        end else begin
          diff        = active_q[i] - target_q[i];
          active_d[i] = active_q[i] - ((diff > SLEW_W) ? SLEW_W : diff);
        end
      end
      pwm_d[i] = (cnt_q < active_q[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      pwm_q   <= '0;
      frame_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= CENTER_W;
        active_q[i] <= CENTER_W;
      end
    end else begin
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
      frame_q <= frame_d;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= target_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign pwm_out_o     = pwm_q;
  assign frame_start_o = frame_q;

endmodule

// File: tb/tb_servo_pwm_array.sv
// Randomised self-checking bench: two instances (no slew / slew 20) share
// buttons; a frame-level model predicts targets, widths and high times.
module tb_servo_pwm_array;

  localparam int PERIOD   = 1000;
  localparam int MINP     = 100;
  localparam int MAXP     = 500;
  localparam int CENTER   = 300;
  localparam int STEP     = 40;
  localparam int DEB      = 8;
  localparam int NCH      = 2;
  localparam int CW       = 12;
  localparam int SLEW_B   = 20;
  localparam int SLOTS    = 22;
  localparam int SLOT_LEN = 40;
  localparam int HOLD     = 20;
  localparam int GLITCH   = 3;

  // plan codes: 0 idle, 1 inc press, 2 dec press, 3 inc+dec together, 4 inc glitch
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    btnInc = '0;
  logic [NCH-1:0]    btnDec = '0;
  logic [NCH-1:0]    pwmA, pwmB;
  logic              frameA, frameB;
  logic [NCH*CW-1:0] widthA, widthB;

  int checks = 0;
  int failures = 0;
  int tgt [NCH];
  int actA [NCH];
  int actB [NCH];
  int plan [NCH][SLOTS];

  always #5 clk = ~clk;

  servo_pwm_array #(
    .PERIOD(PERIOD), .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .CENTER_PULSE(CENTER),
    .STEP(STEP), .SLEW(0), .DEB_CYCLES(DEB), .NUM_CH(NCH), .CW(CW)
  ) dutA (
    .clk_i(clk), .rst_i(rst), .btn_dec_i(btnDec), .btn_inc_i(btnInc),
    .pwm_out_o(pwmA), .frame_start_o(frameA), .width_flat_o(widthA)
  );

  servo_pwm_array #(
    .PERIOD(PERIOD), .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .CENTER_PULSE(CENTER),
    .STEP(STEP), .SLEW(SLEW_B), .DEB_CYCLES(DEB), .NUM_CH(NCH), .CW(CW)
  ) dutB (
    .clk_i(clk), .rst_i(rst), .btn_dec_i(btnDec), .btn_inc_i(btnInc),
    .pwm_out_o(pwmB), .frame_start_o(frameB), .width_flat_o(widthB)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int widthOf(input logic [NCH*CW-1:0] flat, input int ch);
    return int'(flat[ch*CW +: CW]);
  endfunction

  function automatic int modelStep(input int t, input bit inc, input bit dec);
    if (inc && !dec) return (t + STEP > MAXP) ? MAXP : t + STEP;
    if (dec && !inc) return (t - STEP < MINP) ? MINP : t - STEP;
    return t;
  endfunction

  function automatic int slewToward(input int a, input int t, input int lim);
    if (t > a) return a + ((t - a > lim) ? lim : t - a);
    return a - ((a - t > lim) ? lim : a - t);
  endfunction

  task automatic clearPlan();
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < SLOTS; s++) plan[c][s] = 0;
  endtask

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) begin
      tgt[c] = CENTER; actA[c] = CENTER; actB[c] = CENTER;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pwmA"}, int'(pwmA), 0);
    checkOutput({tag, "_pwmB"}, int'(pwmB), 0);
    checkOutput({tag, "_frameA"}, int'(frameA), 0);
    checkOutput({tag, "_frameB"}, int'(frameB), 0);
    for (int c = 0; c < NCH; c++) begin
      checkOutput($sformatf("%s_widthA%0d", tag, c), widthOf(widthA, c), CENTER);
      checkOutput($sformatf("%s_widthB%0d", tag, c), widthOf(widthB, c), CENTER);
    end
  endtask

  task automatic waitFrameStart();
    int guard = 0;
    while (!frameA && guard < PERIOD + 10) begin
      @(negedge clk);
      guard++;
    end
    if (!frameA) checkOutput("frame_start_timeout", 0, 1);
  endtask

  // Runs one whole frame: checks the widths loaded at its boundary, measures
  // the high time of every output, and plays the button plan from slotBase.
  task automatic applyStimulus(input int slotBase);
    int highA [NCH];
    int highB [NCH];
    int fsA, fsB, rel, code;
    bit incL, decL;
    waitFrameStart();
    for (int c = 0; c < NCH; c++) begin
      actA[c] = tgt[c];
      actB[c] = slewToward(actB[c], tgt[c], SLEW_B);
      checkOutput($sformatf("widthA_ch%0d", c), widthOf(widthA, c), actA[c]);
      checkOutput($sformatf("widthB_ch%0d", c), widthOf(widthB, c), actB[c]);
      highA[c] = 0; highB[c] = 0;
    end
    fsA = 0; fsB = 0;
    for (int k = 0; k < PERIOD; k++) begin
      for (int c = 0; c < NCH; c++) begin
        highA[c] += int'(pwmA[c]);
        highB[c] += int'(pwmB[c]);
        incL = 1'b0; decL = 1'b0;
        rel = k - slotBase;
        if (rel >= 0 && rel < SLOTS * SLOT_LEN) begin
          code = plan[c][rel / SLOT_LEN];
          incL = ((code == 1 || code == 3) && (rel % SLOT_LEN) < HOLD) ||
                 (code == 4 && (rel % SLOT_LEN) < GLITCH);
          decL = (code == 2 || code == 3) && (rel % SLOT_LEN) < HOLD;
        end
        btnInc[c] = incL;
        btnDec[c] = decL;
      end
      fsA += int'(frameA);
      fsB += int'(frameB);
      @(negedge clk);
    end
    for (int c = 0; c < NCH; c++) begin
      checkOutput($sformatf("highA_ch%0d", c), highA[c], actA[c]);
      checkOutput($sformatf("highB_ch%0d", c), highB[c], actB[c]);
      for (int s = 0; s < SLOTS; s++) begin
        case (plan[c][s])
          1: tgt[c] = modelStep(tgt[c], 1'b1, 1'b0);
          2: tgt[c] = modelStep(tgt[c], 1'b0, 1'b1);
          3: tgt[c] = modelStep(tgt[c], 1'b1, 1'b1);
          default: ;
        endcase
      end
    end
    checkOutput("frame_starts_A", fsA, 1);
    checkOutput("frame_starts_B", fsB, 1);
  endtask

  task automatic midFrameReset(input int at);
    waitFrameStart();
    repeat (at) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("midreset");
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    int r;
    modelReset();
    clearPlan();
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    repeat (3) applyStimulus(0);

    for (int n = 0; n < 6; n++) begin
      clearPlan();
      plan[0][0] = 1;
      applyStimulus(0);
    end

    clearPlan();
    for (int s = 0; s < 12; s++) plan[0][s] = 2;
    applyStimulus(0);
    clearPlan();
    plan[0][0] = 2;
    applyStimulus(0);

    clearPlan();
    plan[0][0] = 4; plan[0][1] = 3; plan[0][2] = 4;
    plan[1][0] = 3; plan[1][1] = 4;
    for (int s = 3; s < 6; s++) plan[1][s] = 1;
    applyStimulus(0);

    clearPlan();
    plan[1][0] = 2;
    applyStimulus(149);

    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < NCH; c++) begin
        for (int s = 0; s < SLOTS; s++) begin
          r = int'($urandom_range(0, 9));
          plan[c][s] = (r < 5) ? 0 : ((r == 9) ? 1 : r - 4);
        end
      end
      applyStimulus(0);
    end

    clearPlan();
    repeat (6) applyStimulus(0);

    midFrameReset(500);
    repeat (2) applyStimulus(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
